// File: rtl/regex_stream_ctrl_if.sv
// Character stream in / result word out for the regex stream controller.
// master = host side (character source and result sink), slave = controller.
interface regex_stream_ctrl_if #(
   parameter int CHAR_W = 1,
   parameter int POS_W  = 16,
   parameter int CNT_W  = 8
);
   logic              s_valid;
   logic              s_ready;
   logic [CHAR_W-1:0] s_char;
   logic              s_last;
   logic              m_valid;
   logic              m_ready;
   logic              m_match;
   logic [POS_W-1:0]  m_first_end;
   logic [CNT_W-1:0]  m_count;
   logic              m_err;

   modport master (
      output s_valid, s_char, s_last, m_ready,
      input  s_ready, m_valid, m_match, m_first_end, m_count, m_err
   );

   modport slave (
      input  s_valid, s_char, s_last, m_ready,
      output s_ready, m_valid, m_match, m_first_end, m_count, m_err
   );
endinterface

// File: rtl/regex_stream_ctrl.sv
// Sequences one regex matcher engine over character records and returns one
// result word (match, first match end, match count, error) per record.
module regex_stream_ctrl #(
   parameter int CHAR_W   = 1,
   parameter int POS_W    = 16,
   parameter int CNT_W    = 8,
   parameter int ANCHORED = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   regex_stream_ctrl_if.slave   bus,
   output logic                 eng_reset,
   output logic                 eng_i,
   output logic [CHAR_W-1:0]    eng_c,
   input  logic                 eng_o
);

   typedef enum logic [1:0] {
      S_CLEAR,
      S_RUN,
      S_DRAIN,
      S_REPORT
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic               w_fire;
   logic [POS_W-1:0]   r_pos;
   logic [POS_W-1:0]   r_ppos;
   logic               r_pfire;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_match;
   logic [POS_W-1:0]   r_first_end;
   logic               r_err;

   assign bus.m_match     = r_match;
   assign bus.m_first_end = r_first_end;
   assign bus.m_count     = r_cnt;
   assign bus.m_err       = r_err;

   always_comb begin
      w_next      = r_state;
      w_fire      = 1'b0;
      bus.s_ready = 1'b0;
      bus.m_valid = 1'b0;
      eng_i       = 1'b0;
      eng_c       = '0;
      eng_reset   = reset;
      case (r_state)
         S_CLEAR: begin
            eng_reset = 1'b1;
            w_next    = S_RUN;
         end
         S_RUN: begin
            bus.s_ready = ~reset;
            w_fire      = bus.s_valid & ~reset;
            if (w_fire) begin
               eng_c = bus.s_char;
               eng_i = (ANCHORED != 0) ? (r_pos == '0) : 1'b1;
               if (bus.s_last) w_next = S_DRAIN;
            end
         end
         S_DRAIN: w_next = S_REPORT;
         S_REPORT: begin
            bus.m_valid = ~reset;
            if (bus.m_ready) w_next = S_CLEAR;
         end
         default: w_next = S_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_CLEAR;
         r_pos       <= '0;
         r_ppos      <= '0;
         r_pfire     <= 1'b0;
         r_cnt       <= '0;
         r_match     <= 1'b0;
         r_first_end <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_CLEAR) begin
            r_pos       <= '0;
            r_ppos      <= '0;
            r_pfire     <= 1'b0;
            r_cnt       <= '0;
            r_match     <= 1'b0;
            r_first_end <= '0;
            r_err       <= 1'b0;
         end else begin
            // eng_o lags the fired char by one cycle, so it pairs with pfire/ppos
            r_pfire <= w_fire;
            r_ppos  <= r_pos;
            if (r_pfire && eng_o) begin
               if (!(&r_cnt)) r_cnt <= r_cnt + 1'b1;
               if (!r_match) begin
                  r_match     <= 1'b1;
                  r_first_end <= r_ppos;
               end
            end
            if (w_fire) begin
               if (&r_pos) r_err <= 1'b1;
               else        r_pos <= r_pos + 1'b1;
            end
            if (r_state == S_RUN && r_pos != '0 && !bus.s_valid) r_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_regex_stream_ctrl.sv
// Scoreboard bench: two controllers, each driving a behavioural "01" engine,
// with results predicted from the character records themselves.
module tb_regex_stream_ctrl;

   typedef struct packed {
      logic        match;
      logic [15:0] fe;
      logic [7:0]  cnt;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regex_stream_ctrl_if #(.CHAR_W(1), .POS_W(16), .CNT_W(2)) bus0 ();
   regex_stream_ctrl_if #(.CHAR_W(1), .POS_W(3),  .CNT_W(8)) bus1 ();

   logic d_valid [2];
   logic d_char  [2];
   logic d_last  [2];
   logic d_mready[2];

   logic        o_sready[2];
   logic        o_mvalid[2];
   logic        o_match [2];
   logic        o_err   [2];
   logic [15:0] o_fe    [2];
   logic [7:0]  o_cnt   [2];

   logic e_rst0, e_i0, e_c0;
   logic e_rst1, e_i1, e_c1;
   logic e_a0 = 1'b0, e_o0 = 1'b0;
   logic e_a1 = 1'b0, e_o1 = 1'b0;

   assign bus0.s_valid = d_valid[0];
   assign bus0.s_char  = d_char[0];
   assign bus0.s_last  = d_last[0];
   assign bus0.m_ready = d_mready[0];
   assign bus1.s_valid = d_valid[1];
   assign bus1.s_char  = d_char[1];
   assign bus1.s_last  = d_last[1];
   assign bus1.m_ready = d_mready[1];

   assign o_sready[0] = bus0.s_ready;
   assign o_mvalid[0] = bus0.m_valid;
   assign o_match[0]  = bus0.m_match;
   assign o_err[0]    = bus0.m_err;
   assign o_fe[0]     = bus0.m_first_end;
   assign o_cnt[0]    = {6'd0, bus0.m_count};
   assign o_sready[1] = bus1.s_ready;
   assign o_mvalid[1] = bus1.m_valid;
   assign o_match[1]  = bus1.m_match;
   assign o_err[1]    = bus1.m_err;
   assign o_fe[1]     = {13'd0, bus1.m_first_end};
   assign o_cnt[1]    = bus1.m_count;

   regex_stream_ctrl #(.CHAR_W(1), .POS_W(16), .CNT_W(2), .ANCHORED(0)) u0 (
      .clk(clk), .reset(rst), .bus(bus0),
      .eng_reset(e_rst0), .eng_i(e_i0), .eng_c(e_c0), .eng_o(e_o0)
   );

   regex_stream_ctrl #(.CHAR_W(1), .POS_W(3), .CNT_W(8), .ANCHORED(1)) u1 (
      .clk(clk), .reset(rst), .bus(bus1),
      .eng_reset(e_rst1), .eng_i(e_i1), .eng_c(e_c1), .eng_o(e_o1)
   );

   // Engine for "01": a token waits in the '0' cell, the '1' cell registers the match
   always @(posedge clk) begin
      if (e_rst0) begin
         e_a0 <= 1'b0;
         e_o0 <= 1'b0;
      end else begin
         e_a0 <= e_i0 & ~e_c0;
         e_o0 <= e_a0 & e_c0;
      end
   end

   always @(posedge clk) begin
      if (e_rst1) begin
         e_a1 <= 1'b0;
         e_o1 <= 1'b0;
      end else begin
         e_a1 <= e_i1 & ~e_c1;
         e_o1 <= e_a1 & e_c1;
      end
   end

   int   n_checks = 0;
   int   n_err    = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t mon_e;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] bits, input int len, input int gap_after,
                                  input bit anch, input int cmax, input int plim);
      exp_t e;
      e = '0;
      for (int k = 1; k < len; k++) begin
         if (!bits[k-1] && bits[k] && (!anch || k == 1) && gap_after != k - 1) begin
            if (!e.match) begin
               e.match = 1'b1;
               e.fe    = 16'(k);
            end
            if (int'(e.cnt) < cmax) e.cnt = e.cnt + 8'd1;
         end
      end
      e.err = (gap_after >= 0) || (len >= plim);
      return e;
   endfunction

   task automatic compare(input int sel, input exp_t e);
      check($sformatf("m_match%0d", sel),     o_match[sel], e.match);
      check($sformatf("m_first_end%0d", sel), o_fe[sel],    e.fe);
      check($sformatf("m_count%0d", sel),     o_cnt[sel],   e.cnt);
      check($sformatf("m_err%0d", sel),       o_err[sel],   e.err);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (o_mvalid[0] && d_mready[0]) begin
            if (q0.size() == 0) check("unexpected_result0", o_mvalid[0], 1'b0);
            else begin
               mon_e = q0.pop_front();
               compare(0, mon_e);
            end
         end
         if (o_mvalid[1] && d_mready[1]) begin
            if (q1.size() == 0) check("unexpected_result1", o_mvalid[1], 1'b0);
            else begin
               mon_e = q1.pop_front();
               compare(1, mon_e);
            end
         end
      end
   end

   task automatic wait_fire(input int sel);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge clk);
         ok = o_sready[sel];
      end
      if (!ok) check("ready_timeout", o_sready[sel], 1'b1);
      @(posedge clk);
      #1;
   endtask

   task automatic send_record(input int sel, input logic [31:0] bits, input int len,
                              input int gap_after, input int gap_len);
      if (sel == 0) q0.push_back(model(bits, len, gap_after, 1'b0, 3, 65536));
      else          q1.push_back(model(bits, len, gap_after, 1'b1, 255, 8));
      for (int i = 0; i < len; i++) begin
         d_valid[sel] = 1'b1;
         d_char[sel]  = bits[i];
         d_last[sel]  = (i == len - 1);
         wait_fire(sel);
         if (i == gap_after) begin
            d_valid[sel] = 1'b0;
            repeat (gap_len) @(posedge clk);
            #1;
         end
      end
      d_valid[sel] = 1'b0;
      d_last[sel]  = 1'b0;
   endtask

   task automatic wait_drain(input int sel);
      int left;
      left = (sel == 0) ? q0.size() : q1.size();
      for (int n = 0; n < 200 && left != 0; n++) begin
         @(negedge clk);
         left = (sel == 0) ? q0.size() : q1.size();
      end
      check($sformatf("sb_left%0d", sel), left, 0);
   endtask

   initial begin
      bit seen;
      for (int k = 0; k < 2; k++) begin
         d_valid[k]  = 1'b0;
         d_char[k]   = 1'b0;
         d_last[k]   = 1'b0;
         d_mready[k] = 1'b1;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_s_ready0",   o_sready[0], 1'b0);
      check("rst_m_valid0",   o_mvalid[0], 1'b0);
      check("rst_eng_reset0", e_rst0, 1'b1);
      check("rst_eng_i0",     e_i0, 1'b0);
      check("rst_eng_c0",     e_c0, 1'b0);
      check("rst_m_count0",   o_cnt[0], 8'd0);
      check("rst_s_ready1",   o_sready[1], 1'b0);
      check("rst_eng_reset1", e_rst1, 1'b1);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("s_ready_cycle1", o_sready[0], 1'b0);
      check("eng_reset_clear", e_rst0, 1'b1);
      @(negedge clk);
      check("s_ready_cycle2", o_sready[0], 1'b1);
      check("eng_reset_run", e_rst0, 1'b0);
      @(posedge clk);
      #1;

      send_record(0, 32'b101100, 6, -1, 0);
      send_record(0, 32'b011, 3, -1, 0);
      send_record(0, 32'b10, 2, 0, 2);
      send_record(0, 32'b10, 2, -1, 0);
      send_record(0, 32'b10101010, 8, -1, 0);
      send_record(0, 32'b1, 1, -1, 0);

      send_record(1, 32'b101, 3, -1, 0);
      send_record(1, 32'b1010, 4, -1, 0);
      send_record(1, 32'b1101010, 7, -1, 0);
      send_record(1, 32'h1FF, 9, -1, 0);
      send_record(1, 32'b1010, 4, -1, 0);

      // Result held while the consumer stalls
      wait_drain(0);
      @(posedge clk);
      #1 d_mready[0] = 1'b0;
      send_record(0, 32'b10, 2, -1, 0);
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         seen = o_mvalid[0];
      end
      check("m_valid_timeout", o_mvalid[0], 1'b1);
      for (int n = 0; n < 5; n++) begin
         check("hold_s_ready",   o_sready[0], 1'b0);
         check("hold_m_valid",   o_mvalid[0], 1'b1);
         check("hold_m_match",   o_match[0], 1'b1);
         check("hold_first_end", o_fe[0], 16'd1);
         check("hold_m_count",   o_cnt[0], 8'd1);
         check("hold_eng_reset", e_rst0, 1'b0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 d_mready[0] = 1'b1;
      @(negedge clk);
      check("ack_eng_reset_lo", e_rst0, 1'b0);
      @(negedge clk);
      check("ack_eng_reset_hi", e_rst0, 1'b1);
      check("ack_s_ready_lo",   o_sready[0], 1'b0);
      check("ack_m_valid_lo",   o_mvalid[0], 1'b0);
      @(negedge clk);
      check("ack_eng_reset_end", e_rst0, 1'b0);
      check("ack_s_ready_hi",    o_sready[0], 1'b1);
      @(posedge clk);
      #1;

      // Reset mid-record: aborted, no result
      wait_drain(1);
      d_valid[0] = 1'b1;
      d_char[0]  = 1'b0;
      d_last[0]  = 1'b0;
      wait_fire(0);
      d_char[0] = 1'b1;
      wait_fire(0);
      rst        = 1'b1;
      d_valid[0] = 1'b0;
      @(negedge clk);
      check("abort_m_valid",   o_mvalid[0], 1'b0);
      check("abort_eng_reset", e_rst0, 1'b1);
      check("abort_s_ready",   o_sready[0], 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         check("abort_no_result", o_mvalid[0], 1'b0);
      end
      @(posedge clk);
      #1;
      send_record(0, 32'b10, 2, -1, 0);

      wait_drain(0);
      wait_drain(1);
      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
